// File: rtl/acc_cpu_ctrl.sv
`timescale 1ns/1ps
// acc_cpu_ctrl: fetch/decode/execute controller for an 8-bit accumulator machine.
// Instructions are {opcode[2:0], addr[4:0]} words held in an external 32x8 RAM
// with a registered read port. The RAM's read data is valid one cycle after the
// address is presented.
module acc_cpu_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] MEM_RDATA,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic              MEM_WRITE,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] IN_DATA,
  input  logic              IN_VALID,
  output logic              IN_READY,
  output logic [DATA_W-1:0] A_OUT,
  output logic [ADDR_W-1:0] PC_OUT,
  output logic              HALTED
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_INPUT  = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    OP_LOAD  = 3'b000,
    OP_STORE = 3'b001,
    OP_ADD   = 3'b010,
    OP_SUB   = 3'b011,
    OP_IN    = 3'b100,
    OP_JZ    = 3'b101,
    OP_JPOS  = 3'b110,
    OP_HALT  = 3'b111
  } op_t;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   pc;
  logic [DATA_W-1:0]   acc;
  logic [DATA_W-1:0]   ir;
  op_t                 op;
  logic [ADDR_W-1:0]   ir_addr;
  logic                jump;

  assign op      = op_t'(ir[DATA_W-1:ADDR_W]);
  assign ir_addr = ir[ADDR_W-1:0];

  // Branch decision uses the accumulator as left by the previous instruction.
  assign jump = ((op == OP_JZ)   && (acc == '0)) ||
                ((op == OP_JPOS) && !acc[DATA_W-1] && (acc != '0));

  assign MEM_WDATA = acc;
  assign A_OUT     = acc;
  assign PC_OUT    = pc;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  // Next-state and memory/handshake outputs.
  always_comb begin
    state_nxt = state;
    MEM_ADDR  = pc;
    MEM_WRITE = 1'b0;
    IN_READY  = 1'b0;
    HALTED    = 1'b0;
    case (state)
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC: begin
        MEM_ADDR = ir_addr;
        case (op)
          OP_LOAD, OP_ADD, OP_SUB: state_nxt = S_MEM;
          OP_STORE: begin
            // Gated so a reset landing on a STORE never corrupts RAM.
            MEM_WRITE = !reset;
            state_nxt = S_FETCH;
          end
          OP_IN:   state_nxt = S_INPUT;
          OP_HALT: state_nxt = S_HALT;
          default: state_nxt = S_FETCH;
        endcase
      end
      S_MEM:   state_nxt = S_FETCH;
      S_INPUT: begin
        IN_READY = 1'b1;
        if (IN_VALID) state_nxt = S_FETCH;
      end
      S_HALT:  HALTED = 1'b1;
      default: state_nxt = S_FETCH;
    endcase
  end

  // Program counter, instruction register and accumulator updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc  <= '0;
      acc <= '0;
      ir  <= '0;
    end else begin
      case (state)
        S_DECODE: begin
          ir <= MEM_RDATA;
          pc <= pc + 1'b1;
        end
        S_EXEC: begin
          if (jump) pc <= ir_addr;
        end
        S_MEM: begin
          case (op)
            OP_LOAD: acc <= MEM_RDATA;
            OP_ADD:  acc <= acc + MEM_RDATA;
            OP_SUB:  acc <= acc - MEM_RDATA;
            default: acc <= acc;
          endcase
        end
        S_INPUT: begin
          if (IN_VALID) acc <= IN_DATA;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
